// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic matrix multiplier.
package sa_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUT} state_t;

  localparam int ACC_MARGIN = 4;

  // Cycles of zero feed needed for the last beat to reach PE(N-1,N-1).
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int acc_w_default(input int data_w);
    return 2 * data_w + ACC_MARGIN;
  endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// One processing element: forwards a right and b down, accumulates a*b in place.
module sa_mac_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = acc_w_default(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clear,
  input  logic              signed_mode,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  // Full-width product, sign- or zero-extended into the accumulator width.
  function automatic logic [ACC_W-1:0] ext_prod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic              sm);
    logic signed [2*DATA_W-1:0] ps;
    logic        [2*DATA_W-1:0] pu;
    ps = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(y));
    pu = (2*DATA_W)'(x) * (2*DATA_W)'(y);
    if (sm) return ACC_W'(ps);
    else    return ACC_W'(pu);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a;
      b_out <= b;
      if (clear) acc <= '0;
      else       acc <= acc + ext_prod(a, b, signed_mode);
    end
  end

endmodule

// File: rtl/sa_matmul_nxn.sv
// N x N output-stationary systolic multiplier C = A x B with streaming operand
// beats (one A column + one B row per beat) and row-at-a-time result readout.
module sa_matmul_nxn
  import sa_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 4,
  parameter int ACC_W  = acc_w_default(DATA_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   signed_mode,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATA_W-1:0]    in_a_col,
  input  logic [N*DATA_W-1:0]    in_b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_row,
  output logic [N*ACC_W-1:0]     out_data
);

  localparam int KW   = $clog2(N);
  localparam int FLEN = flush_len(N);
  localparam int FW   = $clog2(FLEN + 1);

  state_t          state;
  logic [KW-1:0]   k;
  logic [FW-1:0]   flush_cnt;
  logic            mode_q;
  logic            clear;
  logic            hs;

  logic [DATA_W-1:0] a_h [N][N+1];
  logic [DATA_W-1:0] b_v [N+1][N];
  logic [ACC_W-1:0]  acc [N][N];
  logic              unused_tail;

  assign hs    = in_valid & in_ready;
  assign clear = (state == IDLE) & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      flush_cnt <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            k        <= '0;
            mode_q   <= signed_mode;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (hs) begin
            if (k == KW'(N - 1)) begin
              state     <= FLUSH;
              flush_cnt <= '0;
              in_ready  <= 1'b0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(FLEN - 1)) begin
            state     <= OUT;
            out_row   <= '0;
            out_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_row == KW'(N - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_row   <= '0;
            end else begin
              out_row <= out_row + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skew stage: capture register (zero when no beat) plus i extra delays for row/column i.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_W-1:0] a_skew [0:gi];
    logic [DATA_W-1:0] b_skew [0:gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= gi; d++) begin
          a_skew[d] <= '0;
          b_skew[d] <= '0;
        end
      end else begin
        a_skew[0] <= hs ? in_a_col[gi*DATA_W +: DATA_W] : '0;
        b_skew[0] <= hs ? in_b_row[gi*DATA_W +: DATA_W] : '0;
        for (int d = 1; d <= gi; d++) begin
          a_skew[d] <= a_skew[d-1];
          b_skew[d] <= b_skew[d-1];
        end
      end
    end

    assign a_h[gi][0] = a_skew[gi];
    assign b_v[0][gi] = b_skew[gi];
  end

  // PE array stage: A flows east, B flows south, results stay put.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      sa_mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a_h[gr][gc]),
        .b           (b_v[gr][gc]),
        .clear       (clear),
        .signed_mode (mode_q),
        .a_out       (a_h[gr][gc+1]),
        .b_out       (b_v[gr+1][gc]),
        .acc         (acc[gr][gc])
      );
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++) out_data[j*ACC_W +: ACC_W] = acc[out_row][j];
  end

  // East and south edge outputs leave the array unconsumed.
  always_comb begin
    unused_tail = 1'b0;
    for (int i = 0; i < N; i++) unused_tail = unused_tail ^ (^a_h[i][N]) ^ (^b_v[N][i]);
  end

endmodule

// File: tb/tb_sa_matmul_nxn.sv
// Directed bench: three instances (N=2, N=3, N=4/ACC_W=8) driven one at a time.
module tb_sa_matmul_nxn;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;

  always #5 clk = ~clk;

  logic        b2, d2, ir2, ov2;
  logic [0:0]  r2;
  logic [23:0] od2;
  logic        b3, d3, ir3, ov3;
  logic [1:0]  r3;
  logic [35:0] od3;
  logic        b4, d4, ir4, ov4;
  logic [1:0]  r4;
  logic [31:0] od4;

  sa_matmul_nxn #(.N(2), .DATA_W(4), .ACC_W(12)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(mode), .busy(b2), .done(d2),
    .in_valid(in_valid), .in_ready(ir2), .in_a_col(a_bus[7:0]), .in_b_row(b_bus[7:0]),
    .out_valid(ov2), .out_ready(out_ready), .out_row(r2), .out_data(od2));

  sa_matmul_nxn #(.N(3), .DATA_W(4), .ACC_W(12)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(mode), .busy(b3), .done(d3),
    .in_valid(in_valid), .in_ready(ir3), .in_a_col(a_bus[11:0]), .in_b_row(b_bus[11:0]),
    .out_valid(ov3), .out_ready(out_ready), .out_row(r3), .out_data(od3));

  sa_matmul_nxn #(.N(4), .DATA_W(4), .ACC_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(mode), .busy(b4), .done(d4),
    .in_valid(in_valid), .in_ready(ir4), .in_a_col(a_bus), .in_b_row(b_bus),
    .out_valid(ov4), .out_ready(out_ready), .out_row(r4), .out_data(od4));

  int          sel = 3;
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          done2 = 0, done3 = 0, done4 = 0;
  int          t0;
  int          dprev;
  string       tn = "init";
  logic [15:0] va [4];
  logic [15:0] vb [4];
  logic [63:0] ve [4];

  logic        o_busy, o_done, o_ir, o_ov;
  logic [1:0]  o_row;
  logic [63:0] o_data;

  always_comb begin
    o_busy = 1'b0; o_done = 1'b0; o_ir = 1'b0; o_ov = 1'b0; o_row = '0; o_data = '0;
    case (sel)
      2: begin o_busy = b2; o_done = d2; o_ir = ir2; o_ov = ov2; o_row = 2'(r2); o_data = 64'(od2); end
      3: begin o_busy = b3; o_done = d3; o_ir = ir3; o_ov = ov3; o_row = r3; o_data = 64'(od3); end
      default: begin o_busy = b4; o_done = d4; o_ir = ir4; o_ov = ov4; o_row = r4; o_data = 64'(od4); end
    endcase
  end

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (d2) done2 <= done2 + 1;
    if (d3) done3 <= done3 + 1;
    if (d4) done4 <= done4 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tn, tag, obs, exp);
    end
  endtask

  task automatic go(input int d, input logic m);
    sel = d;
    mode = m;
    start_v[d-2] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    mode = ~m;
    chk("busy after start", 64'(o_busy), 64'(1));
    chk("in_ready in load", 64'(o_ir), 64'(1));
  endtask

  task automatic feed(input int n, input logic [3:0] gap);
    for (int k = 0; k < n; k++) begin
      if (gap[k]) begin
        in_valid = 1'b0; a_bus = 16'hFFFF; b_bus = 16'hFFFF;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; a_bus = va[k]; b_bus = vb[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; a_bus = '0; b_bus = '0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!o_ov && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid arrives", 64'(o_ov), 64'(1));
  endtask

  task automatic read_rows(input int n, input bit stall);
    for (int r = 0; r < n; r++) begin
      if (stall) begin
        out_ready = 1'b0;
        chk("row idx pre-stall", 64'(o_row), 64'(r));
        chk("row data pre-stall", o_data, ve[r]);
        @(posedge clk); #1;
        chk("stall valid held", 64'(o_ov), 64'(1));
        chk("stall idx held", 64'(o_row), 64'(r));
        chk("stall data held", o_data, ve[r]);
      end
      out_ready = 1'b1;
      chk("row valid", 64'(o_ov), 64'(1));
      chk("row idx", 64'(o_row), 64'(r));
      chk("row data", o_data, ve[r]);
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk("done pulse", 64'(o_done), 64'(1));
    chk("valid drop", 64'(o_ov), 64'(0));
    chk("busy drop", 64'(o_busy), 64'(0));
    @(posedge clk); #1;
    chk("done one cycle", 64'(o_done), 64'(0));
  endtask

  initial begin
    tn = "reset";
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sel = 3;
    chk("busy", 64'(o_busy), 64'(0));
    chk("done", 64'(o_done), 64'(0));
    chk("in_ready", 64'(o_ir), 64'(0));
    chk("out_valid", 64'(o_ov), 64'(0));
    chk("out_row", 64'(o_row), 64'(0));
    chk("out_data", o_data, 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3x3 unsigned, A = B = [1..9] row-major
    tn = "t1_3x3";
    va = '{16'h0741, 16'h0852, 16'h0963, 16'h0000};
    vb = '{16'h0321, 16'h0654, 16'h0987, 16'h0000};
    ve = '{64'h02A_024_01E, 64'h060_051_042, 64'h096_07E_066, 64'h0};
    go(3, 1'b0);
    t0 = cyc_cnt;
    feed(3, 4'b0000);
    wait_ov();
    chk("first result latency", 64'(cyc_cnt - t0), 64'(8));
    read_rows(3, 1'b0);
    chk("done count", 64'(done3), 64'(1));

    // 4x4 identity times B, with a stall on every row
    tn = "t2_ident";
    va = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
    vb = '{16'h97E3, 16'h2F50, 16'h681B, 16'hDAC4};
    ve = '{64'h09070E03, 64'h020F0500, 64'h0608010B, 64'h0D0A0C04};
    go(4, 1'b0);
    feed(4, 4'b0000);
    wait_ov();
    read_rows(4, 1'b1);

    // 2x2 signed, then the same bits unsigned
    tn = "t3_signed";
    va = '{16'h003F, 16'h00C2, 16'h0000, 16'h0000};
    vb = '{16'h0078, 16'h0078, 16'h0000, 16'h0000};
    ve = '{64'h007FF8, 64'hFF9008, 64'h0, 64'h0};
    go(2, 1'b1);
    t0 = cyc_cnt;
    feed(2, 4'b0000);
    wait_ov();
    chk("n2 latency", 64'(cyc_cnt - t0), 64'(5));
    read_rows(2, 1'b0);
    tn = "t3_unsigned";
    ve = '{64'h077088, 64'h069078, 64'h0, 64'h0};
    go(2, 1'b0);
    feed(2, 4'b0000);
    wait_ov();
    read_rows(2, 1'b0);

    // Gaps between beats, then an extra beat that must not be taken
    tn = "t4_gaps";
    va = '{16'h0741, 16'h0852, 16'h0963, 16'h0000};
    vb = '{16'h0321, 16'h0654, 16'h0987, 16'h0000};
    ve = '{64'h02A_024_01E, 64'h060_051_042, 64'h096_07E_066, 64'h0};
    go(3, 1'b0);
    feed(3, 4'b0110);
    in_valid = 1'b1; a_bus = 16'hFFFF; b_bus = 16'hFFFF;
    chk("in_ready low after N beats", 64'(o_ir), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; a_bus = '0; b_bus = '0;
    wait_ov();
    read_rows(3, 1'b0);

    // Start pulses while busy are ignored
    tn = "t5_start_busy";
    go(3, 1'b0);
    feed(3, 4'b0000);
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    chk("busy in flush", 64'(o_busy), 64'(1));
    chk("no load in flush", 64'(o_ir), 64'(0));
    wait_ov();
    out_ready = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    chk("out valid kept", 64'(o_ov), 64'(1));
    chk("out row kept", 64'(o_row), 64'(0));
    chk("out data kept", o_data, ve[0]);
    read_rows(3, 1'b0);

    // Reset mid-flush aborts with no done, then a fresh start completes
    tn = "t5_reset";
    go(3, 1'b0);
    feed(3, 4'b0000);
    @(posedge clk); #1;
    dprev = done3;
    rst_n = 1'b0;
    #1;
    chk("busy cleared", 64'(o_busy), 64'(0));
    chk("out_valid cleared", 64'(o_ov), 64'(0));
    chk("in_ready cleared", 64'(o_ir), 64'(0));
    chk("done cleared", 64'(o_done), 64'(0));
    chk("data cleared", o_data, 64'(0));
    #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("stays idle", 64'(o_busy), 64'(0));
    chk("no done after abort", 64'(done3), 64'(dprev));
    go(3, 1'b0);
    feed(3, 4'b0000);
    wait_ov();
    read_rows(3, 1'b0);
    chk("done count after restart", 64'(done3), 64'(dprev + 1));

    // Accumulator wraps modulo 2^8: 4*15*15 = 900 -> 132
    tn = "t6_wrap";
    va = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vb = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    ve = '{64'h84848484, 64'h84848484, 64'h84848484, 64'h84848484};
    go(4, 1'b0);
    feed(4, 4'b0000);
    wait_ov();
    read_rows(4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
